// File: rtl/caliptra_prim_rr_arb_chk.sv
// Hardened round-robin arbiter. The registered onehot grant, its binary index and the valid
// flag are cross-checked every cycle; any inconsistency latches a sticky fatal error.

module caliptra_prim_onehot_chk #(
    parameter int unsigned AddrWidth             = 2,
    parameter int unsigned OneHotWidth           = 4,
    parameter bit          AddrCheck             = 1'b1,
    parameter bit          EnableCheck           = 1'b1,
    parameter bit          StrictCheck           = 1'b1,
    parameter bit          EnableAlertTriggerSVA = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [OneHotWidth-1:0] oh_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   en_i,
    output logic                   err_o
);
    localparam int unsigned Leaves = 2 ** AddrWidth;
    localparam int unsigned Nodes  = 2 * Leaves - 1;

    logic [Leaves-1:0] oh_pad;
    logic [Nodes-1:0]  or_t;
    logic [Nodes-1:0]  multi_t;
    logic              addr_err;
    logic              en_err;

    always_comb begin
        oh_pad = '0;
        oh_pad[OneHotWidth-1:0] = oh_i;
    end

    // Heap-ordered tree: node k has children 2k+1 and 2k+2; leaves start at Leaves-1.
    always_comb begin
        or_t    = '0;
        multi_t = '0;
        for (int i = 0; i < Leaves; i++) begin
            or_t[Leaves-1+i] = oh_pad[i];
        end
        for (int k = Leaves - 2; k >= 0; k--) begin
            or_t[k]    = or_t[2*k+1] | or_t[2*k+2];
            multi_t[k] = multi_t[2*k+1] | multi_t[2*k+2] | (or_t[2*k+1] & or_t[2*k+2]);
        end
    end

    // Padding bits are zero, so an address beyond OneHotWidth also flags.
    if (AddrCheck) begin : g_addr
        assign addr_err = en_i & ~oh_pad[addr_i];
    end else begin : g_no_addr
        assign addr_err = 1'b0;
    end

    always_comb begin
        en_err = 1'b0;
        if (EnableCheck) begin
            en_err = ~en_i & or_t[0];
        end
        if (StrictCheck) begin
            en_err = en_err | (en_i & ~or_t[0]);
        end
    end

    assign err_o = multi_t[0] | addr_err | en_err;

    if (EnableAlertTriggerSVA) begin : g_sva
        c_chk_err: cover property (@(posedge clk_i) disable iff (!rst_ni) err_o);
    end

endmodule

module caliptra_prim_rr_arb_chk #(
    parameter int unsigned N                     = 4,
    parameter int unsigned IdxW                  = $clog2(N),
    parameter bit          EnableAlertTriggerSVA = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N-1:0]    req_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            err_o
);
    localparam logic            StIdle  = 1'b0;
    localparam logic            StHold  = 1'b1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
    localparam logic [IdxW:0]   NCnt    = (IdxW + 1)'(N);

    // Handshake: a grant is transferred in a cycle where valid_o && ready_i; ready_i is
    // ignored while valid_o is low, and the grant is frozen until the handshake.
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    logic            hs;
    logic [IdxW-1:0] ptr_nxt;
    logic [IdxW-1:0] arb_ptr;
    logic [IdxW-1:0] arb_idx;
    logic [IdxW-1:0] cand;
    logic [N-1:0]    arb_req;
    logic [N-1:0]    arb_oh;
    logic            arb_found;
    logic            chk_err;
    logic            ptr_err;

    assign hs      = valid_q & ready_i;
    assign ptr_nxt = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;

    // On a handshake the next winner is picked with the advanced pointer and the
    // just-granted requester masked, giving back-to-back grants without a bubble.
    always_comb begin
        arb_ptr   = hs ? ptr_nxt : ptr_q;
        arb_req   = hs ? (req_i & ~gnt_q) : req_i;
        arb_found = |arb_req;
        arb_idx   = '0;
        cand      = '0;
        for (int off = N - 1; off >= 0; off--) begin
            cand = IdxW'((int'(arb_ptr) + off) % N);
            if (arb_req[cand]) begin
                arb_idx = cand;
            end
        end
        arb_oh = '0;
        arb_oh[arb_idx] = 1'b1;
    end

    always_comb begin
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (valid_q == StIdle || hs) begin
            if (hs) begin
                ptr_d = ptr_nxt;
            end
            if (arb_found) begin
                gnt_d   = arb_oh;
                idx_d   = arb_idx;
                valid_d = StHold;
            end else begin
                gnt_d   = '0;
                idx_d   = '0;
                valid_d = StIdle;
            end
        end
        err_d = err_q | chk_err | ptr_err;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            valid_q <= StIdle;
            err_q   <= 1'b0;
        end else begin
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    caliptra_prim_onehot_chk #(
        .AddrWidth             (IdxW),
        .OneHotWidth           (N),
        .AddrCheck             (1'b1),
        .EnableCheck           (1'b1),
        .StrictCheck           (1'b1),
        .EnableAlertTriggerSVA (EnableAlertTriggerSVA)
    ) u_onehot_chk (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .oh_i   (gnt_q),
        .addr_i (idx_q),
        .en_i   (valid_q),
        .err_o  (chk_err)
    );

    if (N < (2 ** IdxW)) begin : g_ptr_chk
        assign ptr_err = ptr_q > LastIdx;
    end else begin : g_ptr_full
        assign ptr_err = 1'b0;
    end

    assign gnt_o   = gnt_q;
    assign idx_o   = idx_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

    // Handshakes each requester has waited through while holding its request.
    logic [N-1:0][IdxW:0] wait_q, wait_d;

    always_comb begin
        wait_d = wait_q;
        for (int i = 0; i < N; i++) begin
            if (!req_i[i] || (hs && gnt_q[i])) begin
                wait_d[i] = '0;
            end else if (hs && wait_q[i] != '1) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni || err_q || chk_err)
        $onehot0(gnt_q));

    a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni || err_q || chk_err)
        valid_q && !ready_i |=> valid_q && $stable(gnt_q) && $stable(idx_q));

    for (genvar g = 0; g < N; g++) begin : g_live
        a_live: assert property (@(posedge clk_i) disable iff (!rst_ni || err_q)
            wait_q[g] < NCnt);
    end

    c_err_rise: cover property (@(posedge clk_i) disable iff (!rst_ni) $rose(err_q));

endmodule

// File: tb/tb_caliptra_prim_rr_arb_chk.sv
// Bench for caliptra_prim_rr_arb_chk: directed vector table, fault injection, an N=3
// rotation/reset sequence and randomized traffic against a round-robin reference model.

module tb_caliptra_prim_rr_arb_chk;
    localparam int N = 4;

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       ready;
    logic       err;

    logic       rst3_n;
    logic [2:0] req3;
    logic [2:0] gnt3;
    logic [1:0] idx3;
    logic       valid3;
    logic       ready3;
    logic       err3;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: pointer, presented grant
    int   m_ptr;
    int   m_idx;
    logic m_valid;

    vec_t       vecs[$];
    logic [6:0] exp_q[$];
    logic [6:0] exp_v;
    logic [3:0] exp_gnt;
    logic [3:0] pending;
    int         w[4];
    logic       dut_v;
    logic [1:0] dut_g;
    int         exp3[5];

    always #5 clk = ~clk;

    caliptra_prim_rr_arb_chk #(.N(4), .IdxW(2), .EnableAlertTriggerSVA(1'b1)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req),
        .gnt_o   (gnt),
        .idx_o   (idx),
        .valid_o (valid),
        .ready_i (ready),
        .err_o   (err)
    );

    caliptra_prim_rr_arb_chk #(.N(3), .IdxW(2), .EnableAlertTriggerSVA(1'b1)) dut3 (
        .clk_i   (clk),
        .rst_ni  (rst3_n),
        .req_i   (req3),
        .gnt_o   (gnt3),
        .idx_o   (idx3),
        .valid_o (valid3),
        .ready_i (ready3),
        .err_o   (err3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                              input logic ev, input logic ee);
        check({tag, "_gnt"}, 32'(gnt), 32'(eg));
        check({tag, "_idx"}, 32'(idx), 32'(ei));
        check({tag, "_valid"}, 32'(valid), 32'(ev));
        check({tag, "_err"}, 32'(err), 32'(ee));
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic rd, input logic [3:0] g,
                                input logic [1:0] i, input logic v);
        vec_t t;
        t.req = r; t.rdy = rd; t.gnt = g; t.idx = i; t.valid = v;
        return t;
    endfunction

    // First requesting index scanning ptr, ptr+1, ... modulo N; -1 when none.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (r[j[1:0]]) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic rdy);
        int p;
        logic [3:0] masked;
        if (!m_valid) begin
            p = pick(r, m_ptr);
            if (p >= 0) begin
                m_valid = 1'b1;
                m_idx   = p;
            end
        end else if (rdy) begin
            m_ptr  = (m_idx + 1) % N;
            masked = r;
            masked[m_idx[1:0]] = 1'b0;
            p = pick(masked, m_ptr);
            if (p >= 0) begin
                m_idx = p;
            end else begin
                m_valid = 1'b0;
                m_idx   = 0;
            end
        end
    endtask

    task automatic do_reset();
        req   = '0;
        ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst3_n = 1'b0;
        req3   = '0;
        ready3 = 1'b0;

        // Directed table; pointer bookkeeping noted where it matters.
        vecs.push_back(mk(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1));
        vecs.push_back(mk(4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0)); // ptr -> 3
        vecs.push_back(mk(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1));
        vecs.push_back(mk(4'b1001, 1'b1, 4'b0001, 2'd0, 1'b1)); // ptr -> 0, bit 3 masked
        vecs.push_back(mk(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0)); // ptr -> 1
        vecs.push_back(mk(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1));
        vecs.push_back(mk(4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1));
        vecs.push_back(mk(4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1));
        vecs.push_back(mk(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1));
        vecs.push_back(mk(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1));
        vecs.push_back(mk(4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0)); // ptr -> 3
        vecs.push_back(mk(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0010, 1'b0, 4'b0001, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0010, 1'b0, 4'b0001, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0010, 1'b0, 4'b0001, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1));
        vecs.push_back(mk(4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0)); // ptr -> 2
        vecs.push_back(mk(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0));
        vecs.push_back(mk(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0));

        do_reset();
        check_outs("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        for (int v = 0; v < vecs.size(); v++) begin
            req   = vecs[v].req;
            ready = vecs[v].rdy;
            @(posedge clk);
            @(negedge clk);
            check_outs($sformatf("vec%0d", v), vecs[v].gnt, vecs[v].idx, vecs[v].valid, 1'b0);
        end

        // Fault: two grant bits while valid.
        do_reset();
        force dut.gnt_q = 4'b0110;
        force dut.valid_q = 1'b1;
        @(posedge clk);
        #1;
        release dut.gnt_q;
        release dut.valid_q;
        @(negedge clk);
        check("f_multi_err", 32'(err), 32'd1);
        repeat (3) @(negedge clk);
        check("f_multi_sticky", 32'(err), 32'd1);
        do_reset();
        check("f_multi_rst_clears", 32'(err), 32'd0);

        // Fault: index disagrees with onehot grant.
        req = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        req = 4'b0000;
        check_outs("f_addr_pre", 4'b0100, 2'd2, 1'b1, 1'b0);
        force dut.idx_q = 2'd1;
        @(posedge clk);
        #1;
        release dut.idx_q;
        @(negedge clk);
        check("f_addr_err", 32'(err), 32'd1);
        do_reset();

        // Fault: grant bit set while idle.
        check("f_en_pre", 32'(err), 32'd0);
        force dut.gnt_q = 4'b0001;
        @(posedge clk);
        #1;
        release dut.gnt_q;
        @(negedge clk);
        check("f_en_err", 32'(err), 32'd1);
        do_reset();
        check("f_en_rst_clears", 32'(err), 32'd0);

        // N=3: rotation with pointer wrap, then asynchronous reset mid-HOLD.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst3_n = 1'b1;
        check("n3_reset_valid", 32'(valid3), 32'd0);
        exp3 = '{0, 1, 2, 0, 1};
        req3   = 3'b111;
        ready3 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("n3_rot%0d_idx", c), 32'(idx3), 32'(exp3[c]));
            check($sformatf("n3_rot%0d_gnt", c), 32'(gnt3), 32'(3'b001 << exp3[c]));
            check($sformatf("n3_rot%0d_valid", c), 32'(valid3), 32'd1);
        end
        ready3 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("n3_hold_idx", 32'(idx3), 32'd1);
        #2;
        rst3_n = 1'b0;
        #1;
        check("n3_async_gnt", 32'(gnt3), 32'd0);
        check("n3_async_valid", 32'(valid3), 32'd0);
        check("n3_async_idx", 32'(idx3), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst3_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("n3_post_rst_idx", 32'(idx3), 32'd0);
        check("n3_post_rst_valid", 32'(valid3), 32'd1);
        check("n3_err", 32'(err3), 32'd0);

        // Randomized traffic; requesters hold until their grant is accepted.
        do_reset();
        pending = '0;
        for (int i = 0; i < N; i++) w[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 2) == 0) pending[i] = 1'b1;
            end
            req   = pending;
            ready = ($urandom_range(0, 3) != 0);
            dut_v = valid;
            dut_g = idx;
            @(posedge clk);
            model_step(req, ready);
            exp_gnt = m_valid ? (4'b0001 << m_idx) : 4'b0000;
            exp_q.push_back({m_valid, m_idx[1:0], exp_gnt});
            if (dut_v && ready) begin
                for (int i = 0; i < N; i++) begin
                    if (pending[i] && i != int'(dut_g)) w[i]++;
                end
                w[dut_g] = 0;
                pending[dut_g] = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (w[i] >= N) check($sformatf("rnd_fair_r%0d", i), 32'(w[i]), 32'(N - 1));
                end
            end
            @(negedge clk);
            exp_v = exp_q.pop_front();
            check("rnd_valid", 32'(valid), 32'(exp_v[6]));
            check("rnd_idx", 32'(idx), 32'(exp_v[5:4]));
            check("rnd_gnt", 32'(gnt), 32'(exp_v[3:0]));
            check("rnd_err", 32'(err), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
